display_number_sprites: RTL

// - Converts a binary value (e.g. BPM) into NUM_DIGITS decimal digits using sequential double-dabble.
// - Streams one sprite-sheet rectangle per digit, most-significant digit first, to the pixel/blit stage.
// - Blanks leading zeros. Saturates out-of-range values.
// - Sits between the measurement logic and the VGA sprite renderer. Generalises the single-digit

---
 rtl/display_sprite_pkg.sv | 58 +++++
 rtl/bin_to_bcd_seq.sv | 60 ++++++
 rtl/display_number_sprites.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/display_sprite_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_sprite_pkg : sprite-sheet geometry and FSM encoding for digit sprites
// Rev 1.0
// ---------------------------------------------------------------------------
package display_sprite_pkg;

    localparam int SPRITE_COORD_WIDTH    = 11;
    localparam int SPRITE_Y_TOP_DEFAULT    = 281;
    localparam int SPRITE_Y_BOTTOM_DEFAULT = 355;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    function automatic int unsigned digit_x_left(input logic [3:0] d);
        case (d)
            4'd0: return 567;
            4'd1: return 143;
            4'd2: return 172;
            4'd3: return 222;
            4'd4: return 269;
            4'd5: return 319;
            4'd6: return 367;
            4'd7: return 419;
            4'd8: return 464;
            4'd9: return 515;
            default: return 0;
        endcase
    endfunction

    function automatic int unsigned digit_x_right(input logic [3:0] d);
        case (d)
            4'd0: return 608;
            4'd1: return 172;
            4'd2: return 222;
            4'd3: return 269;
            4'd4: return 319;
            4'd5: return 367;
            4'd6: return 419;
            4'd7: return 464;
            4'd8: return 515;
            4'd9: return 567;
            default: return 0;
        endcase
    endfunction

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bin_to_bcd_seq : iterative double-dabble, one input bit per clock
// Rev 1.0
// ---------------------------------------------------------------------------
module bin_to_bcd_seq #(
    parameter int VALUE_WIDTH = 10,
    parameter int NUM_DIGITS  = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [VALUE_WIDTH-1:0]  value,
    output logic                    busy,
    output logic                    done,
    output logic [4*NUM_DIGITS-1:0] bcd
);

    localparam int BCD_WIDTH   = 4 * NUM_DIGITS;
    localparam int COUNT_WIDTH = $clog2(VALUE_WIDTH + 1);

    logic [VALUE_WIDTH-1:0] bin;
    logic [COUNT_WIDTH-1:0] count;
    logic [BCD_WIDTH-1:0]   adjusted;

    always_comb begin
        adjusted = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) adjusted[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // bcd is held after done so the caller can read digits at leisure
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bin   <= '0;
            bcd   <= '0;
            count <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bin   <= value;
                bcd   <= '0;
                count <= '0;
                busy  <= 1'b1;
            end else if (busy) begin
                {bcd, bin} <= {adjusted, bin} << 1;
                count      <= count + 1'b1;
                if (count == COUNT_WIDTH'(VALUE_WIDTH - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/display_number_sprites.sv
`default_nettype none
// ---------------------------------------------------------------------------
// display_number_sprites : binary value -> per-digit sprite rectangles, MSD first
// Rev 1.0
// ---------------------------------------------------------------------------
module display_number_sprites
    import display_sprite_pkg::*;
#(
    parameter int VALUE_WIDTH     = 10,
    parameter int NUM_DIGITS      = 3,
    parameter int COORD_WIDTH     = SPRITE_COORD_WIDTH,
    parameter bit BLANK_LEADING   = 1'b1,
    parameter int SPRITE_Y_TOP    = SPRITE_Y_TOP_DEFAULT,
    parameter int SPRITE_Y_BOTTOM = SPRITE_Y_BOTTOM_DEFAULT,
    localparam int INDEX_WIDTH    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [VALUE_WIDTH-1:0] value_in,
    input  logic                   value_valid,
    output logic                   value_ready,
    output logic                   digit_valid,
    input  logic                   digit_ready,
    output logic [INDEX_WIDTH-1:0] digit_index,
    output logic                   digit_last,
    output logic                   digit_blank,
    output logic [COORD_WIDTH-1:0] sprite_x_left,
    output logic [COORD_WIDTH-1:0] sprite_x_right,
    output logic [COORD_WIDTH-1:0] sprite_y_top,
    output logic [COORD_WIDTH-1:0] sprite_y_bottom,
    output logic                   overflow
);

    localparam int MAX_VALUE = pow10(NUM_DIGITS) - 1;
    localparam int BCD_WIDTH = 4 * NUM_DIGITS;
    localparam logic [INDEX_WIDTH-1:0] LAST_INDEX = INDEX_WIDTH'(NUM_DIGITS - 1);

    state_t                  state, state_next;
    logic                    accept, saturate, load_beat, finish;
    logic                    conv_busy, conv_done;
    logic [VALUE_WIDTH-1:0]  conv_value;
    logic [BCD_WIDTH-1:0]    bcd;
    logic [3:0]              digits [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    zero_run;
    logic [INDEX_WIDTH-1:0]  next_index;
    logic [3:0]              sel_digit;
    logic                    sel_blank;

    assign value_ready = (state == ST_IDLE) && !conv_busy;
    assign accept      = value_valid && value_ready;
    assign saturate    = 64'(value_in) > 64'(MAX_VALUE);
    assign conv_value  = saturate ? VALUE_WIDTH'(MAX_VALUE) : value_in;

    bin_to_bcd_seq #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .NUM_DIGITS  (NUM_DIGITS)
    ) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (accept),
        .value (conv_value),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (bcd)
    );

    // A digit is blank while every digit up to and including it is zero; LSD never blanks
    always_comb begin
        zero_run   = 1'b1;
        blank_mask = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digits[i]     = bcd[4*(NUM_DIGITS-1-i) +: 4];
            zero_run      = zero_run && (digits[i] == 4'd0);
            blank_mask[i] = BLANK_LEADING && zero_run && (i != NUM_DIGITS - 1);
        end
    end

    assign finish     = (state == ST_EMIT) && digit_ready && digit_last;
    assign load_beat  = ((state == ST_CONVERT) && conv_done) ||
                        ((state == ST_EMIT) && digit_ready && !digit_last);
    assign next_index = (state == ST_EMIT) ? digit_index + 1'b1 : '0;
    assign sel_digit  = digits[next_index];
    assign sel_blank  = blank_mask[next_index];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (accept)    state_next = ST_CONVERT;
            ST_CONVERT: if (conv_done) state_next = ST_EMIT;
            ST_EMIT:    if (finish)    state_next = ST_IDLE;
            default:                   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            digit_valid     <= 1'b0;
            digit_index     <= '0;
            digit_last      <= 1'b0;
            digit_blank     <= 1'b0;
            sprite_x_left   <= '0;
            sprite_x_right  <= '0;
            sprite_y_top    <= '0;
            sprite_y_bottom <= '0;
            overflow        <= 1'b0;
        end else begin
            if (accept) overflow <= saturate;
            if (load_beat) begin
                digit_valid <= 1'b1;
                digit_index <= next_index;
                digit_last  <= (next_index == LAST_INDEX);
                digit_blank <= sel_blank;
                if (sel_blank) begin
                    sprite_x_left   <= '0;
                    sprite_x_right  <= '0;
                    sprite_y_top    <= '0;
                    sprite_y_bottom <= '0;
                end else begin
                    sprite_x_left   <= COORD_WIDTH'(digit_x_left(sel_digit));
                    sprite_x_right  <= COORD_WIDTH'(digit_x_right(sel_digit));
                    sprite_y_top    <= COORD_WIDTH'(SPRITE_Y_TOP);
                    sprite_y_bottom <= COORD_WIDTH'(SPRITE_Y_BOTTOM);
                end
            end else if (finish) begin
                digit_valid     <= 1'b0;
                digit_index     <= '0;
                digit_last      <= 1'b0;
                digit_blank     <= 1'b0;
                sprite_x_left   <= '0;
                sprite_x_right  <= '0;
                sprite_y_top    <= '0;
                sprite_y_bottom <= '0;
            end
        end
    end

endmodule
`default_nettype wire
